// File: rtl/xadc_sampler.sv
// xadc_sampler: reads XADC samples over DRP after each eoc and block-averages 2^AVG_LOG2 readings.
module xadc_sampler #(
   parameter logic [6:0] CHANNEL_ADDR = 7'h03,
   parameter int         AVG_LOG2     = 2,
   parameter int         DRDY_TIMEOUT = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        eoc,
   output logic        drp_den,
   output logic        drp_dwe,
   output logic [6:0]  drp_daddr,
   output logic [15:0] drp_di,
   input  logic [15:0] drp_do,
   input  logic        drp_drdy,
   output logic [11:0] sample_out,
   output logic        sample_valid,
   output logic        overrun,
   output logic        timeout
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;
   localparam int AW = 12 + AVG_LOG2;
   localparam logic [AVG_LOG2:0] BLK = (AVG_LOG2 + 1)'(1 << AVG_LOG2);
   localparam logic [7:0] TO_LAST = 8'(DRDY_TIMEOUT - 1);

   logic [0:0]        state_q, state_d;
   logic [7:0]        wcnt_q, wcnt_d;
   logic [AW-1:0]     acc_q, acc_d, acc_sum;
   logic [AVG_LOG2:0] cnt_q, cnt_d, cnt_inc;
   logic [11:0]       sample_q, sample_d;
   logic              den_q, ovr_q, to_q, valid_q;
   logic              drdy_ok, to_hit, blk_done;

   assign drp_dwe      = 1'b0;
   assign drp_di       = '0;
   assign drp_daddr    = CHANNEL_ADDR;
   assign drp_den      = den_q;
   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign overrun      = ovr_q;
   assign timeout      = to_q;

   always_comb begin
      acc_sum  = acc_q + AW'(drp_do[15:4]);
      cnt_inc  = cnt_q + 1'b1;
      drdy_ok  = state_q == WAIT && drp_drdy;
      to_hit   = state_q == WAIT && !drp_drdy && wcnt_q == TO_LAST;
      blk_done = drdy_ok && cnt_inc == BLK;
      state_d  = state_q == IDLE ? (eoc ? WAIT : IDLE) : (drdy_ok || to_hit ? IDLE : WAIT);
      wcnt_d   = state_q == WAIT ? wcnt_q + 8'd1 : '0;
      acc_d    = blk_done ? '0 : drdy_ok ? acc_sum : acc_q;
      cnt_d    = blk_done ? '0 : drdy_ok ? cnt_inc : cnt_q;
      // Truncating divide: keep the 12 bits above the AVG_LOG2 fraction bits.
      sample_d = blk_done ? acc_sum[AVG_LOG2 +: 12] : sample_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         wcnt_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sample_q <= '0;
         den_q    <= 1'b0;
         ovr_q    <= 1'b0;
         to_q     <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sample_q <= sample_d;
         den_q    <= state_q == IDLE && eoc;
         ovr_q    <= state_q == WAIT && eoc;
         to_q     <= to_hit;
         valid_q  <= blk_done;
      end
   end
endmodule

// File: tb/tb_xadc_sampler.sv
// tb_xadc_sampler: directed table-driven checks of a passthrough (AVG_LOG2=0) and a 4-read averaging sampler.
module tb_xadc_sampler;
   logic clk = 1'b0, rst = 1'b1, eoc = 1'b0, drdy = 1'b0;
   logic [15:0] dout = '0;
   logic        den0, dwe0, v0, ov0, to0, den2, dwe2, v2, ov2, to2;
   logic [6:0]  addr0, addr2;
   logic [15:0] di0, di2;
   logic [11:0] s0, s2;
   int checks = 0, errors = 0;

   typedef struct {
      logic [15:0] d;
      logic        v2;
      logic [11:0] s2;
   } rd_t;
   rd_t tbl [12];

   always #5 clk = ~clk;

   xadc_sampler #(.AVG_LOG2(0)) dut0 (
      .clk(clk), .rst(rst), .eoc(eoc), .drp_den(den0), .drp_dwe(dwe0), .drp_daddr(addr0),
      .drp_di(di0), .drp_do(dout), .drp_drdy(drdy), .sample_out(s0), .sample_valid(v0),
      .overrun(ov0), .timeout(to0));
   xadc_sampler #(.AVG_LOG2(2)) dut2 (
      .clk(clk), .rst(rst), .eoc(eoc), .drp_den(den2), .drp_dwe(dwe2), .drp_daddr(addr2),
      .drp_di(di2), .drp_do(dout), .drp_drdy(drdy), .sample_out(s2), .sample_valid(v2),
      .overrun(ov2), .timeout(to2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // eoc, den next cycle, drdy three cycles after den, result one cycle after drdy.
   task automatic do_read(input logic [15:0] d, input logic exp_v2, input logic [11:0] exp_s2);
      @(negedge clk) eoc = 1'b1;
      @(negedge clk) eoc = 1'b0;
      check("den", {den0, den2}, 2'b11);
      @(negedge clk) check("den_pulse", {den0, den2}, 2'b00);
      @(negedge clk) begin drdy = 1'b1; dout = d; end
      @(negedge clk) drdy = 1'b0;
      check("valid0", v0, 1'b1);
      check("sample0", s0, d[15:4]);
      check("valid2", v2, exp_v2);
      check("sample2", s2, exp_s2);
      @(negedge clk) check("valid_pulse", {v0, v2}, 2'b00);
   endtask

   initial begin
      int n;
      logic saw_v;
      tbl = '{
         '{16'hABC0, 1'b0, 12'h000}, '{16'hABC0, 1'b0, 12'h000},
         '{16'hABC0, 1'b0, 12'h000}, '{16'hABC0, 1'b1, 12'hABC},
         '{16'h1000, 1'b0, 12'hABC}, '{16'h1010, 1'b0, 12'hABC},
         '{16'h1020, 1'b0, 12'hABC}, '{16'h1040, 1'b1, 12'h101},
         '{16'h0200, 1'b0, 12'h101}, '{16'h0200, 1'b0, 12'h101},
         '{16'h0400, 1'b0, 12'h101}, '{16'h0400, 1'b1, 12'h030}};
      #1 check("reset_out", {den0, v0, ov0, to0, s0, den2, v2, ov2, to2, s2}, '0);
      check("consts", {dwe0, addr0, di0, dwe2, addr2, di2}, {1'b0, 7'h03, 16'h0, 1'b0, 7'h03, 16'h0});
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i == 8) begin
            @(negedge clk) eoc = 1'b1;
            @(negedge clk) eoc = 1'b0;
            check("to_den", den2, 1'b1);
            n = 1;
            saw_v = 1'b0;
            while (!to2 && n < 100) begin
               @(negedge clk) n++;
               saw_v |= v2 | v0;
            end
            check("to_cycle", n, 64);
            check("to_both", {to0, to2}, 2'b11);
            check("to_no_valid", saw_v, 1'b0);
            @(negedge clk) check("to_pulse", {to0, to2}, 2'b00);
         end
         do_read(tbl[i].d, tbl[i].v2, tbl[i].s2);
      end
      // Second eoc one cycle after den: dropped with a one-cycle overrun.
      @(negedge clk) eoc = 1'b1;
      @(negedge clk) eoc = 1'b0;
      check("ov_den", den2, 1'b1);
      @(negedge clk) eoc = 1'b1;
      check("ov_den_pulse", den2, 1'b0);
      @(negedge clk) eoc = 1'b0;
      check("overrun", {ov0, ov2}, 2'b11);
      check("ov_no_den", {den0, den2}, 2'b00);
      @(negedge clk) begin drdy = 1'b1; dout = 16'h0050; end
      check("ov_pulse", {ov0, ov2}, 2'b00);
      @(negedge clk) drdy = 1'b0;
      check("ov_read0", {v0, s0}, {1'b1, 12'h005});
      check("ov_no_den2", {den0, den2}, 2'b00);
      // Reset mid-block, stray drdy in IDLE, then a fresh block of full-scale readings.
      do_read(16'hFFF0, 1'b0, 12'h030);
      do_read(16'hFFF0, 1'b0, 12'h030);
      @(negedge clk) rst = 1'b1;
      #1 check("rst_mid", {v0, s0, v2, s2, den2}, '0);
      @(negedge clk) rst = 1'b0;
      @(negedge clk) begin drdy = 1'b1; dout = 16'h1230; end
      @(negedge clk) drdy = 1'b0;
      check("idle_drdy", {v0, s0, v2, s2}, '0);
      for (int i = 0; i < 4; i++) do_read(16'hFFF0, i == 3, i == 3 ? 12'hFFF : 12'h000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/xadc_sampler.md
Name: xadc_sampler

Overview:
Upstream acquisition stage of the scope datapath: reads converted samples from the XADC over its DRP port after each end-of-conversion and block-averages 2^AVG_LOG2 readings. It delivers a 12-bit sample with a one-cycle valid strobe to the trigger/capture stage. It also flags DRP timeouts and conversion overruns.

Parameters:
CHANNEL_ADDR, 7'h03, DRP address of the sampled channel (VP/VN status register)
AVG_LOG2, 2, log2 of readings averaged per output sample (0..4; 0 = passthrough)
DRDY_TIMEOUT, 63, max cycles to wait for drp_drdy after den before aborting (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
eoc  in  1  XADC end-of-conversion pulse, 1 cycle
drp_den  out  1  DRP enable, 1-cycle pulse per read
drp_dwe  out  1  DRP write enable, constant 0
drp_daddr  out  7  DRP address, = CHANNEL_ADDR
drp_di  out  16  DRP write data, constant 0
drp_do  in  16  DRP read data, result in [15:4]
drp_drdy  in  1  DRP read-data-ready pulse
sample_out  out  12  averaged sample, held between updates
sample_valid  out  1  1-cycle strobe, sample_out updated this cycle
overrun  out  1  1-cycle pulse, eoc dropped because a read was in flight
timeout  out  1  1-cycle pulse, DRP read aborted

Behaviour:
- Reset (async, rst=1): state IDLE, accumulator=0, reading count=0, wait counter=0. All outputs are 0 (drp_daddr=CHANNEL_ADDR). No partial average survives reset.
- All outputs are registered. drp_dwe=0, drp_di=0 and drp_daddr=CHANNEL_ADDR at all times.
- FSM states are IDLE and WAIT.
- IDLE: eoc=1 -> drp_den=1 in the next cycle only; state WAIT; wait counter=0. drp_drdy in IDLE is ignored.
- WAIT: wait counter increments each cycle.
  - drp_drdy=1: data = drp_do[15:4]; acc_new = acc + data (width 12+AVG_LOG2, no overflow possible); count increments; return to IDLE.
  - No drdy before the counter reaches DRDY_TIMEOUT: timeout pulses 1 cycle; the reading is discarded; acc and count are unchanged; return to IDLE.
  - eoc=1 in WAIT (including the same cycle as drdy or timeout): overrun pulses 1 cycle; the eoc is dropped, never queued.
- Output: when the drdy reading completes a block (count reaches 2^AVG_LOG2):
  - In the cycle after drdy: sample_out = acc_new >> AVG_LOG2 (truncating) and sample_valid=1.
  - acc and count clear in that same cycle.
- Latency: eoc at cycle t -> den at t+1. drdy at cycle d -> sample_valid at d+1 for block-completing readings.
- AVG_LOG2=0: every successful read yields sample_out = drp_do[15:4] one cycle after drdy.
- Minimum eoc-to-eoc spacing without overrun: read latency + 1 cycle.
- Throughput: at most one sample_valid per 2^AVG_LOG2 successful reads.

Test Plan:
- AVG_LOG2=0: eoc, then drdy 3 cycles after den with drp_do=16'hABC0 -> den 1 cycle after eoc; sample_out=12'hABC; sample_valid pulse 1 cycle after drdy.
- AVG_LOG2=2: four reads of 12'h100, 12'h101, 12'h102, 12'h104 -> one sample_valid, sample_out=12'h101 (1031>>2); no valid after the first three.
- DRDY_TIMEOUT=63, drdy withheld -> timeout pulse when the counter reaches 63; no sample_valid; a following 4-read block still averages only its own 4 readings.
- Second eoc 1 cycle after den, drdy later -> overrun=1 for 1 cycle; only one den issued; the first read completes normally.
- rst asserted after 2 of 4 readings -> outputs 0 immediately; the next 4 readings of 12'hFFF give sample_out=12'hFFF (no stale accumulation).
- drdy pulse while IDLE with no den outstanding -> no change to acc, count or outputs.
